// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed memory slave with a four-phase MEM_EN/MFC
//               handshake, a fixed wait latency and out-of-range detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  // log2 of the internal word depth; supported range 1..16
  parameter int unsigned ADDR_BITS = 8,
  // wait cycles spent in WAIT before the access; supported range 0..15
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,      // synchronous, active-low
  input  logic        MEM_EN,
  input  logic        MEM_RW,     // 1 = read, 0 = write
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        MFC,
  output logic        mem_err
);

  localparam int unsigned C_DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0]  C_LATENCY = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   rw_q, rw_d;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [15:0]            data_out_q, data_out_d;
  logic                   mfc_q, mfc_d;
  logic                   err_q, err_d;

  // Storage array; deliberately not reset so contents survive a reset.
  logic [15:0]            mem_q [C_DEPTH];

  logic                   oob;
  logic [ADDR_BITS-1:0]   idx;
  logic [15:0]            rd_word;
  logic                   access_fire;

  // Out-of-range means any captured address bit above the array index is set.
  if (ADDR_BITS < 16) begin : g_oob_check
    assign oob = |addr_q[15:ADDR_BITS];
  end else begin : g_no_oob
    assign oob = 1'b0;
  end

  assign idx     = addr_q[ADDR_BITS-1:0];
  assign rd_word = mem_q[idx];

  // Next-state, request capture and access decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_out_d  = data_out_q;
    access_fire = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Inputs are only looked at here; afterwards the captured copy rules.
        if (MEM_EN) begin
          state_d = S_WAIT;
          cnt_d   = C_LATENCY;
          rw_d    = MEM_RW;
          addr_d  = addr;
          wdata_d = data_in;
        end
      end
      S_WAIT: begin
        // Committed request: MEM_EN is ignored until the access is done.
        if (cnt_q == 4'd0) begin
          state_d     = S_ACK;
          access_fire = 1'b1;
          if (rw_q) begin
            data_out_d = oob ? 16'h0000 : rd_word;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        // Leaving ACK consumes this edge, so a new request needs an IDLE edge.
        if (!MEM_EN) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered and follow the ACK state exactly.
    mfc_d = (state_d == S_ACK);
    err_d = (state_d == S_ACK) && oob;
  end

  // Control and datapath registers with reset priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      data_out_q <= 16'h0000;
      mfc_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      mfc_q      <= mfc_d;
      err_q      <= err_d;
    end
  end

  // Array write on the WAIT->ACK edge; an active reset discards it.
  always_ff @(posedge clk) begin
    if (reset && access_fire && !rw_q && !oob) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign MFC      = mfc_q;
  assign mem_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed plus randomized bench for mem_responder, running
//               three instances (LATENCY 2, 0, 4) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 0, 4};

  logic        clk;
  logic        rst_n;
  logic        en   [NI];
  logic        rw   [NI];
  logic [15:0] ad   [NI];
  logic [15:0] din  [NI];
  logic [15:0] dout [NI];
  logic        mfc  [NI];
  logic        err  [NI];

  int n_checks = 0;
  int n_err    = 0;
  int cur      = 0;

  // Behavioural model: plain word arrays plus the last value read per instance.
  logic [15:0] mdl_mem  [NI][256];
  logic [15:0] exp_dout [NI];
  logic [15:0] pool     [8];

  mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n), .MEM_EN(en[0]), .MEM_RW(rw[0]), .addr(ad[0]),
    .data_in(din[0]), .data_out(dout[0]), .MFC(mfc[0]), .mem_err(err[0]));
  mem_responder #(.ADDR_BITS(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_n), .MEM_EN(en[1]), .MEM_RW(rw[1]), .addr(ad[1]),
    .data_in(din[1]), .data_out(dout[1]), .MFC(mfc[1]), .mem_err(err[1]));
  mem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(rst_n), .MEM_EN(en[2]), .MEM_RW(rw[2]), .addr(ad[2]),
    .data_in(din[2]), .data_out(dout[2]), .MFC(mfc[2]), .mem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  // One complete transaction; expectations come from the model, not the DUT.
  task automatic access(input int i, input bit is_rd, input logic [15:0] a,
                        input logic [15:0] d, input int drop_after,
                        input int hold, input bit rel_rst);
    int  k;
    bit  seen;
    bit  oob;
    bit  aborted;
    cur = i;
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    en[i] = 1'b1; rw[i] = is_rd; ad[i] = a; din[i] = d;
    @(posedge clk); #1;
    chk("mfc_low_after_sample", 32'(mfc[i]), 32'd0);
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (drop_after != 0 && k >= drop_after) en[i] = 1'b0;
      rw[i] = 1'($urandom); ad[i] = 16'($urandom); din[i] = 16'($urandom);
      @(posedge clk); #1;
      seen = mfc[i];
    end
    chk("mfc_rise_edge", 32'(k), 32'(LAT[i] + 1));

    oob = (a[15:8] != 8'h00);
    if (is_rd) exp_dout[i] = oob ? 16'h0000 : mdl_mem[i][a[7:0]];
    else if (!oob) mdl_mem[i][a[7:0]] = d;
    chk("mem_err_in_ack", 32'(err[i]), 32'(oob));
    chk("data_out_at_ack", 32'(dout[i]), 32'(exp_dout[i]));

    aborted = (drop_after != 0) && (drop_after <= LAT[i] + 1);
    if (aborted) begin
      @(negedge clk);
      @(posedge clk); #1;
      chk("mfc_pulse_end", 32'(mfc[i]), 32'd0);
      chk("err_pulse_end", 32'(err[i]), 32'd0);
    end else begin
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        rw[i] = 1'($urandom); ad[i] = 16'($urandom); din[i] = 16'($urandom);
        @(posedge clk); #1;
        chk("mfc_hold", 32'(mfc[i]), 32'd1);
        chk("err_hold", 32'(err[i]), 32'(oob));
      end
      @(negedge clk);
      en[i] = 1'b0;
      @(posedge clk); #1;
      chk("mfc_fall", 32'(mfc[i]), 32'd0);
      chk("err_fall", 32'(err[i]), 32'd0);
    end
    chk("data_out_hold", 32'(dout[i]), 32'(exp_dout[i]));
  endtask

  initial begin
    int highs;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      en[i] = 1'b0; rw[i] = 1'b0; ad[i] = 16'h0000; din[i] = 16'h0000;
      exp_dout[i] = 16'h0000;
    end

    // Reset state of every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      cur = i;
      chk("reset_mfc", 32'(mfc[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
      chk("reset_dout", 32'(dout[i]), 32'd0);
    end

    // Write then read at LATENCY 2; reset released on the first sampling edge.
    access(0, 1'b0, 16'h0010, 16'hBEEF, 0, 1, 1'b1);
    access(0, 1'b1, 16'h0010, 16'h0000, 0, 2, 1'b0);

    // LATENCY 0: MFC after one edge, held five cycles while EN stays high.
    access(1, 1'b0, 16'h0020, 16'h1357, 0, 1, 1'b0);
    access(1, 1'b1, 16'h0020, 16'h0000, 0, 5, 1'b0);

    // Out-of-range write aliases to index 0 but must not land there.
    access(0, 1'b0, 16'h0000, 16'hCAFE, 0, 1, 1'b0);
    access(0, 1'b0, 16'h0100, 16'h1234, 0, 2, 1'b0);
    access(0, 1'b1, 16'h0000, 16'h0000, 0, 1, 1'b0);
    access(0, 1'b1, 16'h0100, 16'h0000, 0, 2, 1'b0);

    // EN dropped one cycle into WAIT at LATENCY 4: one-cycle MFC at edge 5.
    access(2, 1'b0, 16'h0003, 16'h5A5A, 1, 1, 1'b0);
    access(2, 1'b1, 16'h0003, 16'h0000, 0, 1, 1'b0);

    // Reset in WAIT discards a pending write.
    access(2, 1'b0, 16'h0007, 16'h0001, 0, 1, 1'b0);
    cur = 2;
    @(negedge clk);
    en[2] = 1'b1; rw[2] = 1'b0; ad[2] = 16'h0007; din[2] = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; en[2] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      cur = i;
      exp_dout[i] = 16'h0000;
      chk("rst_wait_mfc", 32'(mfc[i]), 32'd0);
      chk("rst_wait_dout", 32'(dout[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mfc[2]) highs++;
    end
    cur = 2;
    chk("rst_wait_no_mfc", 32'(highs), 32'd0);
    access(2, 1'b1, 16'h0007, 16'h0000, 0, 1, 1'b0);

    // Back-to-back: second request raised right after MFC falls.
    access(0, 1'b0, 16'h0042, 16'hA1A1, 0, 1, 1'b0);
    access(0, 1'b1, 16'h0042, 16'h0000, 0, 1, 1'b0);
    access(0, 1'b1, 16'h0010, 16'h0000, 0, 1, 1'b0);

    // EN held during reset: only the first edge out of reset samples it.
    @(negedge clk);
    rst_n = 1'b0; en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 16'h0010;
    repeat (3) @(posedge clk);
    #1;
    cur = 0;
    chk("en_in_reset_mfc", 32'(mfc[0]), 32'd0);
    for (int i = 0; i < NI; i++) exp_dout[i] = 16'h0000;
    access(0, 1'b1, 16'h0010, 16'h0000, 0, 1, 1'b1);

    // Randomized traffic over a small address pool, plus out-of-range hits.
    for (int j = 0; j < 8; j++) pool[j] = 16'($urandom_range(0, 255));
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 8; j++)
        access(i, 1'b0, pool[j], 16'($urandom), 0, 1, 1'b0);
      for (int n = 0; n < 25; n++) begin
        logic [15:0] a;
        int          drop;
        a = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 4) == 0) a[15:8] = 8'($urandom_range(1, 255));
        drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT[i] + 1) : 0;
        access(i, 1'($urandom), a, 16'($urandom), drop,
               $urandom_range(1, 3), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
